dbg_run_ctrl: RTL and testbench
===============================

# dbg_run_ctrl

Multi-hart debug run-control core in the sys_clk domain. It takes pre-synchronised single-cycle halt/resume/step strobes from the JTAG test logic, applies them to a hart-select mask, and drives one glitch-free gated clock per hart. Each hart has its own RUN/HALT/STEP state machine, multi-cycle stepping, and an external halt input. A cycle-count breakpoint is an optional compile-time feature.

## Interface
- NUM_HARTS, 2, number of independently gated harts (1..8)
- STEP_W, 4, width of the step-count operand
- CNT_W, 16, width of the breakpoint cycle counter (used only with DBG_BREAK_EN)

Ports:
- sys_clk  in  1  system clock; all state on posedge, except the clock-gate latch (see Operation)
- dbg_rst  in  1  reset, asynchronous, active-low
- hart_sel  in  NUM_HARTS  mask of harts addressed by the strobes; sampled with each strobe
- halt_req  in  1  one-cycle strobe, request halt
- resume_req  in  1  one-cycle strobe, request resume
- step_req  in  1  one-cycle strobe, request step
- step_count  in  STEP_W  cycles per step, sampled with step_req; value 0 is treated as 1
- ext_halt  in  NUM_HARTS  level, hart-originated halt request (e.g. ebreak)
- break_arm  in  1  one-cycle strobe, arm breakpoint on selected harts (only with DBG_BREAK_EN)
- break_cycles  in  CNT_W  breakpoint compare value (only with DBG_BREAK_EN)
- dbg_clk  out  NUM_HARTS  gated clocks, sys_clk & gate[i]
- halted  out  NUM_HARTS  1 when hart i is in HALT
- stepping  out  NUM_HARTS  1 when hart i is in STEP

## Operation

Per-hart state, encoding: RUN=2'b00, HALT=2'b01, STEP=2'b10.
- Each hart has: state, clk_en, step remaining counter rem[STEP_W], and gate.
- gate is captured from clk_en on negedge sys_clk.
- dbg_clk[i] = sys_clk & gate[i], so the gated clock is glitch-free.

Strobes apply only to harts with hart_sel[i]=1. Priority when events coincide: halt (halt_req or ext_halt) > resume > step.
- RUN: on halt_req&sel or ext_halt[i]:
  - go to HALT, clk_en=0.
  - step_req and resume_req are ignored in this state.
- HALT:
  - On resume_req&sel: go to RUN, clk_en=1.
  - Else on step_req&sel: go to STEP, clk_en=1, rem=max(step_count,1).
  - ext_halt has no effect in this state.
- STEP:
  - On halt_req&sel or ext_halt[i]: go to HALT, clk_en=0 (step aborted).
  - Else on resume_req&sel: go to RUN (remaining count discarded).
  - Else if rem==1: go to HALT, clk_en=0.
  - Else: rem=rem-1.
- Unused state encoding 2'b11: go to HALT, clk_en=0.

Reset values (while dbg_rst=0):
- state=RUN, clk_en=1, gate=1 (gate is also asynchronously set), rem=0.
- Outputs: halted=0, stepping=0, dbg_clk follows sys_clk.

## Timing
- Strobe sampled at posedge k:
  - clk_en updates at posedge k.
  - gate updates at negedge k.
- Halt at k: the last dbg_clk high phase is the one beginning at posedge k. No pulses from posedge k+1 onward.
- Resume at k: dbg_clk pulses resume from posedge k+1.
- Step of N at k: exactly N dbg_clk pulses, at posedges k+1..k+N.
  - halted=1 again after posedge k+N.
  - stepping=1 from after posedge k through posedge k+N.
- ext_halt has the same latency as halt_req.
- Reset deasserted mid-step: the hart returns to RUN with the clock running. No partial-pulse glitch is allowed.
- Harts operate fully independently. A strobe with hart_sel=0 is a no-op.

## Configuration
DBG_BREAK_EN defined:
- Ports break_arm and break_cycles exist.
- Per hart: armed bit and cnt[CNT_W].
- break_arm&sel sets armed=1 and cnt=0.
- While armed and in RUN, cnt increments each sys_clk cycle.
- When armed and cnt==break_cycles-1 (break_cycles=0 treated as 1), the hart halts as if halt_req was received in that cycle, and armed clears.
- cnt holds its value in HALT/STEP.
- break_arm on a halted hart arms it; counting starts after resume.
- cnt wraps modulo 2^CNT_W.
- Reset: armed=0, cnt=0.

DBG_BREAK_EN undefined: the ports, counters and compare logic are absent.

## Test plan
- Reset release, no strobes -> halted=00, 10 dbg_clk pulses on both harts in 10 cycles.
- halt_req, hart_sel=01 at posedge 5 -> dbg_clk[0] last pulse at 5, halted=01; hart 1 keeps pulsing.
- Hart 0 halted; step_req, step_count=3 at posedge 10 -> pulses at 11,12,13 only; halted[0]=1 after 13. Repeat with step_count=0 -> exactly 1 pulse.
- step_count=8 with halt_req at the 2nd step cycle -> 2 pulses, then HALT. Same-cycle halt_req+resume_req while halted -> remains halted.
- ext_halt[1] pulsed while in RUN -> halted[1]=1 with halt_req latency; dbg_rst asserted during STEP -> halted=0, clocks free-running the next cycle.
- DBG_BREAK_EN, break_cycles=20, break_arm with hart_sel=10 while running -> hart 1 gets exactly 20 pulses, then halts, armed clears; hart 0 unaffected.

Source files
------------

// File: rtl/dbg_run_ctrl.sv
// Multi-hart debug run control: halt/resume/step FSM and glitch-free clock gate per hart.
// Optional cycle-count breakpoint is compiled in when DBG_BREAK_EN is defined.
module dbg_run_ctrl #(
    parameter int NUM_HARTS = 2,
    parameter int STEP_W    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 dbg_rst,
    input  logic [NUM_HARTS-1:0] hart_sel,
    input  logic                 halt_req,
    input  logic                 resume_req,
    input  logic                 step_req,
    input  logic [STEP_W-1:0]    step_count,
    input  logic [NUM_HARTS-1:0] ext_halt,
`ifdef DBG_BREAK_EN
    input  logic                 break_arm,
    input  logic [CNT_W-1:0]     break_cycles,
`endif
    output logic [NUM_HARTS-1:0] dbg_clk,
    output logic [NUM_HARTS-1:0] halted,
    output logic [NUM_HARTS-1:0] stepping
);

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    logic [NUM_HARTS-1:0] sel_halt;
    logic [NUM_HARTS-1:0] sel_resume;
    logic [NUM_HARTS-1:0] sel_step;
    logic [STEP_W-1:0]    step_load;

    assign sel_halt   = hart_sel & {NUM_HARTS{halt_req}};
    assign sel_resume = hart_sel & {NUM_HARTS{resume_req}};
    assign sel_step   = hart_sel & {NUM_HARTS{step_req}};

    // A zero step count still advances the hart by one cycle
    assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;

`ifdef DBG_BREAK_EN
    logic [NUM_HARTS-1:0] sel_arm;
    logic [CNT_W-1:0]     brk_last;

    assign sel_arm  = hart_sel & {NUM_HARTS{break_arm}};
    // Last counted cycle before the break fires; zero behaves like one
    assign brk_last = (break_cycles == '0) ? '0
                                           : break_cycles - CNT_W'(1);
`else
    logic [CNT_W-1:0] brk_unused;
    assign brk_unused = '0;
`endif

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [1:0]        state;
        logic              clk_en;
        logic [STEP_W-1:0] rem;
        logic              gate;
        logic              brk_hit;
        logic              stop;

`ifdef DBG_BREAK_EN
        logic             armed;
        logic [CNT_W-1:0] cnt;

        assign brk_hit = armed && (state == ST_RUN) && (cnt == brk_last);

        // Breakpoint counter: runs only while armed and the hart is free-running
        always_ff @(posedge sys_clk or negedge dbg_rst) begin
            if (!dbg_rst) begin
                armed <= 1'b0;
                cnt   <= '0;
            end else if (sel_arm[h]) begin
                armed <= 1'b1;
                cnt   <= '0;
            end else if (brk_hit) begin
                armed <= 1'b0;
            end else if (armed && (state == ST_RUN)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
`else
        assign brk_hit = 1'b0;
`endif

        // Any halt source that can stop a running or stepping hart
        assign stop = sel_halt[h] | ext_halt[h] | brk_hit;

        // Run-control FSM; halt outranks resume, resume outranks step
        always_ff @(posedge sys_clk or negedge dbg_rst) begin
            if (!dbg_rst) begin
                state  <= ST_RUN;
                clk_en <= 1'b1;
                rem    <= '0;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (stop) begin
                            state  <= ST_HALT;
                            clk_en <= 1'b0;
                        end
                    end
                    ST_HALT: begin
                        if (sel_halt[h]) begin
                            clk_en <= 1'b0;
                        end else if (sel_resume[h]) begin
                            state  <= ST_RUN;
                            clk_en <= 1'b1;
                        end else if (sel_step[h]) begin
                            state  <= ST_STEP;
                            clk_en <= 1'b1;
                            rem    <= step_load;
                        end
                    end
                    ST_STEP: begin
                        if (stop) begin
                            state  <= ST_HALT;
                            clk_en <= 1'b0;
                            rem    <= '0;
                        end else if (sel_resume[h]) begin
                            state  <= ST_RUN;
                            clk_en <= 1'b1;
                            rem    <= '0;
                        end else if (rem == STEP_W'(1)) begin
                            state  <= ST_HALT;
                            clk_en <= 1'b0;
                            rem    <= '0;
                        end else begin
                            rem <= rem - STEP_W'(1);
                        end
                    end
                    default: begin
                        state  <= ST_HALT;
                        clk_en <= 1'b0;
                        rem    <= '0;
                    end
                endcase
            end
        end

        // Gate enable moves only while sys_clk is low, so no runt pulses
        always_ff @(negedge sys_clk or negedge dbg_rst) begin
            if (!dbg_rst) begin
                gate <= 1'b1;
            end else begin
                gate <= clk_en;
            end
        end

        assign dbg_clk[h]  = sys_clk & gate;
        assign halted[h]   = (state == ST_HALT);
        assign stepping[h] = (state == ST_STEP);
    end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed bench for dbg_run_ctrl: table of strobe vectors plus reset and breakpoint sequences.
// Pulse counts are taken from free-running edge counters on each gated clock.
module tb_dbg_run_ctrl;

    logic       sys_clk;
    logic       dbg_rst;
    logic [1:0] hart_sel;
    logic       halt_req;
    logic       resume_req;
    logic       step_req;
    logic [3:0] step_count;
    logic [1:0] ext_halt;
    logic [1:0] dbg_clk;
    logic [1:0] halted;
    logic [1:0] stepping;
`ifdef DBG_BREAK_EN
    logic        break_arm;
    logic [15:0] break_cycles;
`endif

    int n_chk;
    int n_fail;
    int p0;
    int p1;
    int b0;
    int b1;

    dbg_run_ctrl #(
        .NUM_HARTS(2),
        .STEP_W(4),
        .CNT_W(16)
    ) dut (
        .sys_clk(sys_clk),
        .dbg_rst(dbg_rst),
        .hart_sel(hart_sel),
        .halt_req(halt_req),
        .resume_req(resume_req),
        .step_req(step_req),
        .step_count(step_count),
        .ext_halt(ext_halt),
`ifdef DBG_BREAK_EN
        .break_arm(break_arm),
        .break_cycles(break_cycles),
`endif
        .dbg_clk(dbg_clk),
        .halted(halted),
        .stepping(stepping)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial p0 = 0;
    initial p1 = 0;
    always @(posedge dbg_clk[0]) p0 <= p0 + 1;
    always @(posedge dbg_clk[1]) p1 <= p1 + 1;

    typedef struct {
        logic [1:0] sel;
        logic       h;
        logic       r;
        logic       s;
        logic [3:0] cnt;
        logic [1:0] ext;
        int         wcyc;
        logic [1:0] eh;
        logic [1:0] es;
        int         ep0;
        int         ep1;
    } vec_t;

    vec_t v[18];

    function automatic vec_t mk(
        logic [1:0] sel, logic h, logic r, logic s,
        logic [3:0] cnt, logic [1:0] ext, int wcyc,
        logic [1:0] eh, logic [1:0] es, int ep0, int ep1);
        vec_t t;
        t.sel = sel; t.h = h; t.r = r; t.s = s;
        t.cnt = cnt; t.ext = ext; t.wcyc = wcyc;
        t.eh = eh; t.es = es; t.ep0 = ep0; t.ep1 = ep1;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        hart_sel   = 2'b00;
        halt_req   = 1'b0;
        resume_req = 1'b0;
        step_req   = 1'b0;
        step_count = 4'd0;
        ext_halt   = 2'b00;
`ifdef DBG_BREAK_EN
        break_arm  = 1'b0;
`endif
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        dbg_rst = 1'b0;
        idle();
`ifdef DBG_BREAK_EN
        break_cycles = 16'd0;
`endif

        //      sel    h    r    s    cnt   ext  w  halted st  p0  p1
        v[0]  = mk(2'b00,1'b0,1'b0,1'b0,4'd0,2'b00,9,2'b00,2'b00,10,10);
        v[1]  = mk(2'b01,1'b1,1'b0,1'b0,4'd0,2'b00,2,2'b01,2'b00, 1, 3);
        v[2]  = mk(2'b01,1'b0,1'b0,1'b1,4'd3,2'b00,3,2'b01,2'b00, 3, 4);
        v[3]  = mk(2'b01,1'b0,1'b0,1'b1,4'd0,2'b00,2,2'b01,2'b00, 1, 3);
        v[4]  = mk(2'b01,1'b0,1'b0,1'b1,4'd8,2'b00,0,2'b00,2'b01, 0, 1);
        v[5]  = mk(2'b00,1'b0,1'b0,1'b0,4'd0,2'b00,0,2'b00,2'b01, 1, 1);
        v[6]  = mk(2'b01,1'b1,1'b0,1'b0,4'd0,2'b00,2,2'b01,2'b00, 1, 3);
        v[7]  = mk(2'b01,1'b1,1'b1,1'b0,4'd0,2'b00,2,2'b01,2'b00, 0, 3);
        v[8]  = mk(2'b10,1'b0,1'b0,1'b1,4'd2,2'b00,1,2'b01,2'b00, 0, 2);
        v[9]  = mk(2'b00,1'b0,1'b1,1'b0,4'd0,2'b00,1,2'b01,2'b00, 0, 2);
        v[10] = mk(2'b01,1'b0,1'b1,1'b0,4'd0,2'b00,2,2'b00,2'b00, 2, 3);
        v[11] = mk(2'b00,1'b0,1'b0,1'b0,4'd0,2'b10,2,2'b10,2'b00, 3, 1);
        v[12] = mk(2'b10,1'b0,1'b1,1'b0,4'd0,2'b10,2,2'b00,2'b00, 3, 2);
        v[13] = mk(2'b11,1'b1,1'b0,1'b0,4'd0,2'b00,0,2'b11,2'b00, 1, 1);
        v[14] = mk(2'b01,1'b0,1'b1,1'b1,4'd3,2'b00,1,2'b10,2'b00, 1, 0);
        v[15] = mk(2'b01,1'b0,1'b0,1'b1,4'd2,2'b01,1,2'b11,2'b00, 1, 0);
        v[16] = mk(2'b10,1'b0,1'b0,1'b1,4'd2,2'b10,2,2'b11,2'b00, 0, 2);
        v[17] = mk(2'b11,1'b0,1'b0,1'b1,4'd15,2'b00,3,2'b00,2'b11,3, 3);

        // Reset held: outputs idle
        repeat (3) tick();
        chk("rst_halted", 32'(halted), 32'(2'b00));
        chk("rst_stepping", 32'(stepping), 32'(2'b00));
        dbg_rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            b0 = p0;
            b1 = p1;
            hart_sel   = v[i].sel;
            halt_req   = v[i].h;
            resume_req = v[i].r;
            step_req   = v[i].s;
            step_count = v[i].cnt;
            ext_halt   = v[i].ext;
            tick();
            idle();
            repeat (v[i].wcyc) tick();
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v[i].eh));
            chk($sformatf("v%0d_stepping", i), 32'(stepping), 32'(v[i].es));
            chk($sformatf("v%0d_pulses0", i), 32'(p0 - b0), 32'(v[i].ep0));
            chk($sformatf("v%0d_pulses1", i), 32'(p1 - b1), 32'(v[i].ep1));
        end

        // Reset asserted while both harts are mid-step
        b0 = p0;
        b1 = p1;
        dbg_rst = 1'b0;
        #1;
        chk("midstep_rst_halted", 32'(halted), 32'(2'b00));
        chk("midstep_rst_stepping", 32'(stepping), 32'(2'b00));
        repeat (3) tick();
        chk("rst_pulses0", 32'(p0 - b0), 32'd3);
        chk("rst_pulses1", 32'(p1 - b1), 32'd3);
        dbg_rst = 1'b1;
        b0 = p0;
        b1 = p1;
        repeat (5) tick();
        chk("post_rst_pulses0", 32'(p0 - b0), 32'd5);
        chk("post_rst_pulses1", 32'(p1 - b1), 32'd5);
        chk("post_rst_halted", 32'(halted), 32'(2'b00));

`ifdef DBG_BREAK_EN
        // Arm hart 1 for a 20-cycle break while both run
        break_cycles = 16'd20;
        hart_sel  = 2'b10;
        break_arm = 1'b1;
        tick();
        idle();
        b0 = p0;
        b1 = p1;
        repeat (25) tick();
        chk("brk_pulses0", 32'(p0 - b0), 32'd25);
        chk("brk_pulses1", 32'(p1 - b1), 32'd20);
        chk("brk_halted", 32'(halted), 32'(2'b10));
        hart_sel   = 2'b10;
        resume_req = 1'b1;
        tick();
        idle();
        repeat (30) tick();
        chk("brk_disarmed", 32'(halted), 32'(2'b00));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
